// File: rtl/alu_ctrl_if.sv
// ------------------------------------------------------------------
// alu_ctrl_if : request/result handshake bundle for alu_ctrl. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface alu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [5:0]  ctrl;
  logic [15:0] a;
  logic [15:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        zr;
  logic        ng;
  logic        busy;

  modport master (
    output in_valid, op, ctrl, a, b, res_ready,
    input  in_ready, res_valid, result, zr, ng, busy
  );

  modport slave (
    input  in_valid, op, ctrl, a, b, res_ready,
    output in_ready, res_valid, result, zr, ng, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl.sv
// ------------------------------------------------------------------
// alu_ctrl : PASS / shift-and-add MUL sequencer around a Hack ALU. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_ctrl #(
  parameter int MUL_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctrl_if.slave     bus
);

  localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [5:0] CTRL_ADD = 6'b000010;
  localparam logic [5:0] CTRL_X   = 6'b001100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic        op_q, op_d;
  logic [15:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        zr_q, zr_d, ng_q, ng_d;

  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_c;
  logic [15:0] x_z, x_n, y_z, y_n, f_out;
  logic        alu_zr, alu_ng;

  // op_q selects the operand source: it is only ever consumed in EXEC/MUL
  always_comb begin
    alu_x   = op_q ? acc_q : a_q;
    alu_y   = op_q ? mcand_q : b_q;
    alu_c   = op_q ? (mplier_q[0] ? CTRL_ADD : CTRL_X) : ctrl_q;
    x_z     = alu_c[5] ? 16'h0000 : alu_x;
    x_n     = alu_c[4] ? ~x_z : x_z;
    y_z     = alu_c[3] ? 16'h0000 : alu_y;
    y_n     = alu_c[2] ? ~y_z : y_z;
    f_out   = alu_c[1] ? (x_n + y_n) : (x_n & y_n);
    alu_out = alu_c[0] ? ~f_out : f_out;
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.a;
          b_d    = bus.b;
          ctrl_d = bus.ctrl;
          op_d   = bus.op;
          if (bus.op) begin
            acc_d    = 16'h0000;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            cnt_d    = 5'd0;
            state_d  = MUL;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        result_d = alu_out;
        zr_d     = alu_zr;
        ng_d     = alu_ng;
        state_d  = DONE;
      end
      MUL: begin
        acc_d    = alu_out;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = alu_out;
          zr_d     = alu_zr;
          ng_d     = alu_ng;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      ctrl_q   <= 6'b000000;
      op_q     <= 1'b0;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      cnt_q    <= 5'd0;
      result_q <= 16'h0000;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ------------------------------------------------------------------
// tb_alu_ctrl : directed-vector bench for alu_ctrl. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  alu_ctrl_if bus ();

  alu_ctrl #(.MUL_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Issue one request; leaves the block in DONE unless do_release is set.
  task automatic run_op(input string tag, input logic op, input logic [5:0] ctrl,
                        input logic [15:0] a, input logic [15:0] b, input int lat,
                        input logic [15:0] exp_res, input logic exp_zr,
                        input logic exp_ng, input bit do_release);
    int cyc;
    wait_ready();
    bus.op       = op;
    bus.ctrl     = ctrl;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    bus.ctrl     = 6'b111111;
    bus.op       = ~op;
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    cyc = 1;
    while (!bus.res_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_res"}, {16'd0, bus.result}, {16'd0, exp_res});
    check({tag, "_zr"}, {31'd0, bus.zr}, {31'd0, exp_zr});
    check({tag, "_ng"}, {31'd0, bus.ng}, {31'd0, exp_ng});
    if (do_release) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.ctrl      = 6'b000000;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_zr", {31'd0, bus.zr}, 32'd0);
    check("rst_ng", {31'd0, bus.ng}, 32'd0);

    // res_ready with no result pending must not disturb IDLE
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("idle_res_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op("pass_add", 1'b0, 6'b000010, 16'd42, 16'd129, 2, 16'h00AB, 1'b0, 1'b0, 1'b1);
    run_op("pass_m1", 1'b0, 6'b111010, 16'h1248, 16'h137F, 2, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    run_op("pass_notx", 1'b0, 6'b001101, 16'h1248, 16'h137F, 2, 16'hEDB7, 1'b0, 1'b1, 1'b1);
    run_op("mul_7x6", 1'b1, 6'b000000, 16'd7, 16'd6, 17, 16'h002A, 1'b0, 1'b0, 1'b1);
    run_op("mul_neg", 1'b1, 6'b000000, 16'hFFFF, 16'd3, 17, 16'hFFFD, 1'b0, 1'b1, 1'b1);
    run_op("mul_trunc", 1'b1, 6'b000000, 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("mul_b0", 1'b1, 6'b000000, 16'h1234, 16'h0000, 17, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: a new request held during DONE must not be taken
    run_op("bp", 1'b0, 6'b000010, 16'd10, 16'd20, 2, 16'd30, 1'b0, 1'b0, 1'b0);
    bus.op       = 1'b0;
    bus.ctrl     = 6'b000010;
    bus.a        = 16'd1;
    bus.b        = 16'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_result", {16'd0, bus.result}, 32'd30);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_idle", {31'd0, bus.in_ready}, 32'd1);
    check("bp_not_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("bp_taken", {31'd0, bus.busy}, 32'd1);
    tick();
    check("bp2_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("bp2_result", {16'd0, bus.result}, 32'd2);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Reset in the middle of a multiply
    wait_ready();
    bus.op       = 1'b1;
    bus.a        = 16'd7;
    bus.b        = 16'd6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_mul_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    run_op("post_rst", 1'b0, 6'b000010, 16'd3, 16'd4, 2, 16'h0007, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Multi-cycle sequencer wrapped around one instance of the 16-bit Hack-style ALU (ports out, zr, ng, x, y, zx, nx, zy, ny, f, no).
- Accepts one operation at a time over a valid/ready handshake.
- Runs either a single raw ALU pass or a 16-bit shift-and-add multiply built from repeated ALU passes.
- Returns the result and zr/ng flags over a second valid/ready handshake.
- Sits between the CPU/issue logic and the shared ALU datapath.

Parameters:
MUL_CYCLES, 16, number of multiplier bits processed by MUL (legal 1..16); result is the low 16 bits of a * b[MUL_CYCLES-1:0]

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request (high only in IDLE)
op  input  1  0 = PASS (single ALU pass), 1 = MUL
ctrl  input  6  {zx,nx,zy,ny,f,no} for PASS; ignored for MUL
a  input  16  operand x (multiplicand for MUL)
b  input  16  operand y (multiplier for MUL)
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
result  output  16  registered result
zr  output  1  registered: result == 0
ng  output  1  registered: result[15]
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE
  - result = 0, zr = 0, ng = 0, res_valid = 0, busy = 0, all internal registers = 0
  - in_ready = 1 from the first cycle after reset
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch a, b, ctrl and op into a_r, b_r, ctrl_r and op_r.
  - op = 0: next state EXEC.
  - op = 1: acc = 0, mcand = a, mplier = b, cnt = 0; next state MUL.
- EXEC (one cycle):
  - ALU x = a_r, y = b_r, control = ctrl_r.
  - result <= ALU out, zr <= ALU zr, ng <= ALU ng.
  - Next state DONE.
- MUL (exactly MUL_CYCLES cycles; no early exit):
  - ALU x = acc, y = mcand.
  - If mplier[0] = 1, control = 000010 (x+y); else control = 001100 (x & -1, i.e. pass x).
  - Every cycle: acc <= ALU out; mcand <= mcand << 1 (zero-fill); mplier <= mplier >> 1 (zero-fill); cnt <= cnt + 1.
  - On the cycle where cnt == MUL_CYCLES-1: result <= ALU out, zr <= (ALU out == 0), ng <= ALU out[15]; next state DONE.
  - All arithmetic is modulo 2^16; overflow is silently truncated; operands are treated as two's complement and the low 16 bits of the product are correct for signed or unsigned operands.
- DONE:
  - res_valid = 1; result, zr and ng are held stable.
  - When res_ready = 1: next state IDLE.
  - No same-cycle bypass: the next request is accepted no earlier than the cycle after the result handshake.
- Latency, counted from the accept edge T:
  - PASS: res_valid high in cycle T+2.
  - MUL: res_valid high in cycle T+1+MUL_CYCLES (T+17 at default).
- Boundary conditions:
  - in_valid outside IDLE is ignored and nothing is latched; in_ready is low in those states.
  - Input changes after acceptance have no effect on the operation in progress.
  - res_ready while res_valid = 0 is ignored.
  - Reset asserted mid-EXEC, mid-MUL or in DONE aborts the operation and discards the result; IDLE state and reset values are seen the next cycle.
  - MUL with b = 0 or a = 0 still takes the full MUL_CYCLES cycles and returns 0 with zr = 1.
- The ALU is purely combinational; no ALU output feeds an output port directly. All outputs are registered or decoded from state.

Test Plan:
1. PASS a=42, b=129, ctrl=000010 -> result 0x00AB, zr=0, ng=0; res_valid first high at T+2; busy high in T+1..T+2.
2. PASS a=0x1248, b=0x137F, ctrl=111010 -> result 0xFFFF, ng=1. Then ctrl=001101 -> result 0xEDB7, ng=1.
3. MUL a=7, b=6 -> result 0x002A, zr=0, ng=0, res_valid first at T+17. MUL a=0xFFFF, b=3 -> 0xFFFD, ng=1.
4. MUL a=0x0100, b=0x0100 -> 0x0000, zr=1 (truncation). MUL a=0x1234, b=0 -> 0x0000, zr=1, still T+17.
5. Backpressure: after a PASS completes, hold res_ready=0 for 5 cycles while pulsing in_valid with a new request -> result/flags unchanged, in_ready=0, request not taken. Raise res_ready -> IDLE the next cycle; the request is accepted only after that.
6. Reset for one cycle at MUL cycle 8 -> next cycle res_valid=0, result=0, busy=0, in_ready=1. A following PASS a=3, b=4, ctrl=000010 -> 0x0007.
